// File: rtl/ins_fetch_queue_if.sv
// Bundles the instruction-memory, decoder-handshake and redirect signals of the fetch queue.
// The master modport is the fetch stage; the slave modport is its environment.
interface ins_fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_valid;
  logic [31:0]   imem_data;
  logic [31:0]   ins;
  logic [31:0]   ins_pc;
  logic          ins_valid;
  logic          ins_ready;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, ins, ins_pc, ins_valid, count,
    input  imem_valid, imem_data, ins_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ins, ins_pc, ins_valid, count,
    output imem_valid, imem_data, ins_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ins_fetch_queue.sv
// Fetch stage: sequential PC generation, single-outstanding instruction reads and an
// in-order word FIFO whose head is presented to the decoder; redirect flushes and restarts.
module ins_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  ins_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;

  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ins_q, ins_d;
  logic [31:0]   ins_pc_q, ins_pc_d;
  logic          ins_valid_q, ins_valid_d;

  logic          req_fire;
  logic          push;
  logic          pop;

  // Space is reserved when the request leaves, so a later push can never overflow.
  assign req_fire = rst_n && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !bus.redirect;
  assign push     = (state_q == WAIT) && bus.imem_valid && !bus.redirect;
  assign pop      = ins_valid_q && bus.ins_ready && !bus.redirect;

  assign bus.imem_req  = req_fire;
  assign bus.imem_addr = req_fire ? pc_q : 32'h0;
  assign bus.ins       = ins_q;
  assign bus.ins_pc    = ins_pc_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.count     = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= PC_RESET;
      req_pc_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
          end else if (req_fire) begin
            state_q  <= WAIT;
            req_pc_q <= pc_q;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            pc_q    <= bus.redirect_pc;
            state_q <= bus.imem_valid ? IDLE : DROP;
          end else if (bus.imem_valid) begin
            pc_q    <= pc_q + PC_STEP;
            state_q <= IDLE;
          end
        end
        DROP: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
          end
          // The stale response always ends DROP, even alongside a fresh redirect.
          if (bus.imem_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.imem_data;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ins_d       = 32'h0;
    ins_pc_d    = 32'h0;
    ins_valid_d = 1'b0;
    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // Next head is either an entry already stored or the word being pushed right now.
      if (count_d != '0) begin
        ins_valid_d = 1'b1;
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          ins_d    = bus.imem_data;
          ins_pc_d = req_pc_q;
        end else begin
          ins_d    = data_mem[rd_ptr_d];
          ins_pc_d = pc_mem[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ins_q       <= 32'h0;
      ins_pc_q    <= 32'h0;
      ins_valid_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      ins_valid_q <= ins_valid_d;
    end
  end
endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: a per-cycle vector table for steady fetch, then
// hand-written sequences for back-pressure, redirects, full queue, PC wrap and reset.
module tb_ins_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] XORK  = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;

  ins_fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  ins_fetch_queue_if #(.DEPTH(DEPTH)) bus2 ();

  ins_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  ins_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2)
  );

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t tv [9];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          n_req;
  int          n_pop;
  logic [31:0] req_addr [32];
  logic [31:0] exp_pop_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sample after inputs settle: log requests into the memory model, score pops.
  task automatic settle();
    #1;
    if (bus.redirect === 1'b1) check32("no_req_in_redirect", {31'b0, bus.imem_req}, 32'd0);
    if (bus.imem_req === 1'b1) begin
      check32("single_outstanding", {31'b0, pend}, 32'd0);
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = bus.imem_addr;
      if (n_req < 32) req_addr[n_req] = bus.imem_addr;
      n_req++;
      $display("req  addr=%h", bus.imem_addr);
    end
    if (bus.ins_valid && bus.ins_ready && !bus.redirect) begin
      $display("pop  pc=%h ins=%h", bus.ins_pc, bus.ins);
      check32("pop_pc", bus.ins_pc, exp_pop_pc);
      check32("pop_ins", bus.ins, exp_pop_pc ^ XORK);
      exp_pop_pc = exp_pop_pc + 32'd4;
      n_pop++;
    end
    if (bus.redirect) exp_pop_pc = bus.redirect_pc;
    check32("count_bound", {31'b0, (bus.count <= DEPTH)}, 32'd1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    bus.imem_valid = 1'b0;
    bus.imem_data  = 32'h0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = pend_addr ^ XORK;
        pend           = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.ins_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_valid  = 1'b0;
    bus.imem_data   = 32'h0;
    pend            = 1'b0;
    lat             = 1;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check32("rst_addr", bus.imem_addr, 32'h0);
    check32("rst_valid", {31'b0, bus.ins_valid}, 32'd0);
    check32("rst_ins", bus.ins, 32'h0);
    check32("rst_ins_pc", bus.ins_pc, 32'h0);
    check32("rst_count", {29'b0, bus.count}, 32'd0);
    rst_n      = 1'b1;
    n_req      = 0;
    n_pop      = 0;
    exp_pop_pc = 32'h0;
  endtask

  logic [31:0] exp2 [3];
  int          k2;
  logic        req2_seen;
  logic [31:0] req2_addr;

  task automatic cyc2();
    #1;
    req2_seen = bus2.imem_req;
    req2_addr = bus2.imem_addr;
    if (bus2.ins_valid && bus2.ins_ready) begin
      $display("pop2 pc=%h ins=%h", bus2.ins_pc, bus2.ins);
      if (k2 < 3) begin
        check32("wrap_pc", bus2.ins_pc, exp2[k2]);
        check32("wrap_ins", bus2.ins, exp2[k2] ^ XORK);
      end
      k2++;
    end
    @(posedge clk);
    #1;
    bus2.imem_valid = req2_seen;
    bus2.imem_data  = req2_seen ? (req2_addr ^ XORK) : 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0,       3'd0};
    tv[1] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0,       3'd0};
    tv[2] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0, 32'hA5A50000, 3'd1};
    tv[3] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0,       3'd0};
    tv[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 32'hA5A50004, 3'd1};
    tv[5] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0,       3'd0};
    tv[6] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h8, 32'hA5A50008, 3'd1};
    tv[7] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0,       3'd0};
    tv[8] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'hA5A5000C, 3'd1};
    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;

    rst2_n           = 1'b0;
    bus2.imem_valid  = 1'b0;
    bus2.imem_data   = 32'h0;
    bus2.ins_ready   = 1'b0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'h0;

    // Steady fetch with 1-cycle memory
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.ins_ready = tv[i].ready;
      settle();
      check32($sformatf("t1_req[%0d]", i), {31'b0, bus.imem_req}, {31'b0, tv[i].exp_req});
      if (tv[i].exp_req) check32($sformatf("t1_addr[%0d]", i), bus.imem_addr, tv[i].exp_addr);
      check32($sformatf("t1_valid[%0d]", i), {31'b0, bus.ins_valid}, {31'b0, tv[i].exp_valid});
      if (tv[i].exp_valid) begin
        check32($sformatf("t1_pc[%0d]", i), bus.ins_pc, tv[i].exp_pc);
        check32($sformatf("t1_ins[%0d]", i), bus.ins, tv[i].exp_ins);
      end
      check32($sformatf("t1_count[%0d]", i), {29'b0, bus.count}, {29'b0, tv[i].exp_count});
      advance();
    end

    // Back-pressure fills the queue, then draining resumes fetch at 0x10
    do_reset();
    repeat (20) cyc();
    check32("bp_nreq", n_req, 4);
    for (int i = 0; i < 4; i++) check32($sformatf("bp_addr[%0d]", i), req_addr[i], 32'(4 * i));
    settle();
    check32("bp_count", {29'b0, bus.count}, 32'd4);
    check32("bp_no_req", {31'b0, bus.imem_req}, 32'd0);
    advance();
    bus.ins_ready = 1'b1;
    for (int t = 0; t < 40 && n_pop < 5; t++) cyc();
    check32("bp_drain_pops", {31'b0, (n_pop >= 5)}, 32'd1);
    check32("bp_resume_addr", req_addr[4], 32'h10);

    // Redirect while a 5-cycle response is in flight
    do_reset();
    lat           = 5;
    bus.ins_ready = 1'b1;
    cyc();
    cyc();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    cyc();
    bus.redirect = 1'b0;
    for (int t = 0; t < 3; t++) begin
      settle();
      check32("drop_no_req", {31'b0, bus.imem_req}, 32'd0);
      advance();
    end
    settle();
    check32("redir_req", {31'b0, bus.imem_req}, 32'd1);
    check32("redir_addr", bus.imem_addr, 32'h100);
    check32("redir_count", {29'b0, bus.count}, 32'd0);
    advance();
    for (int t = 0; t < 30 && n_pop < 1; t++) cyc();
    check32("redir_first_pop", n_pop, 1);

    // Redirect coincident with imem_valid and ins_ready at count=3
    do_reset();
    repeat (7) cyc();
    bus.ins_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    settle();
    check32("coin_pre_count", {29'b0, bus.count}, 32'd3);
    advance();
    bus.redirect  = 1'b0;
    bus.ins_ready = 1'b0;
    settle();
    check32("coin_count", {29'b0, bus.count}, 32'd0);
    check32("coin_valid", {31'b0, bus.ins_valid}, 32'd0);
    check32("coin_req", {31'b0, bus.imem_req}, 32'd1);
    check32("coin_addr", bus.imem_addr, 32'h200);
    advance();
    bus.ins_ready = 1'b1;
    for (int t = 0; t < 20 && n_pop < 1; t++) cyc();
    check32("coin_first_pop", n_pop, 1);

    // Push and pop together on the response, then refill to full
    do_reset();
    repeat (7) cyc();
    bus.ins_ready = 1'b1;
    settle();
    check32("pp_pre_count", {29'b0, bus.count}, 32'd3);
    advance();
    bus.ins_ready = 1'b0;
    settle();
    check32("pp_count", {29'b0, bus.count}, 32'd3);
    check32("pp_req", {31'b0, bus.imem_req}, 32'd1);
    check32("pp_addr", bus.imem_addr, 32'h10);
    advance();
    cyc();
    settle();
    check32("full_count", {29'b0, bus.count}, 32'd4);
    check32("full_no_req", {31'b0, bus.imem_req}, 32'd0);
    advance();
    bus.ins_ready = 1'b1;
    for (int t = 0; t < 30 && n_pop < 6; t++) cyc();
    check32("full_drain_pops", {31'b0, (n_pop >= 6)}, 32'd1);
    rst_n = 1'b0;

    // Second instance: PC wrap past 2^32, then reset asserted in WAIT
    repeat (2) @(posedge clk);
    #1;
    check32("rst2_valid", {31'b0, bus2.ins_valid}, 32'd0);
    check32("rst2_count", {29'b0, bus2.count}, 32'd0);
    rst2_n         = 1'b1;
    bus2.ins_ready = 1'b1;
    k2             = 0;
    for (int t = 0; t < 20 && k2 < 3; t++) cyc2();
    check32("wrap_pops", k2, 3);
    bus2.ins_ready = 1'b0;
    req2_seen      = 1'b0;
    for (int t = 0; t < 10 && !req2_seen; t++) cyc2();
    check32("wait_reached", {31'b0, req2_seen}, 32'd1);
    rst2_n = 1'b0;
    @(posedge clk);
    #1;
    bus2.imem_valid = 1'b0;
    check32("wrst_req", {31'b0, bus2.imem_req}, 32'd0);
    check32("wrst_addr", bus2.imem_addr, 32'h0);
    check32("wrst_valid", {31'b0, bus2.ins_valid}, 32'd0);
    check32("wrst_ins", bus2.ins, 32'h0);
    check32("wrst_ins_pc", bus2.ins_pc, 32'h0);
    check32("wrst_count", {29'b0, bus2.count}, 32'd0);
    rst2_n = 1'b1;
    #1;
    check32("wrst_restart_req", {31'b0, bus2.imem_req}, 32'd1);
    check32("wrst_restart_addr", bus2.imem_addr, 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
